exc_irq_ctrl: RTL and testbench

- Parametrised exception/interrupt controller for the LEGv8 core.
- Successor to the single-line ExtIRQ/ExtIAck path inside the controller; widened to N_IRQ external lines with per-line enable, edge or level capture, fixed priority and an invalid-opcode trap.
- Sits beside the controller.
- Drives Exc/EStatus to the datapath, receives ExcAck from the datapath and ERet from the main decoder.

---
 rtl/exc_irq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_exc_irq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller for the LEGv8 core: N_IRQ prioritised external
// lines plus an invalid-opcode trap, handshaked with the datapath via Exc/ExcAck.
module exc_irq_ctrl #(
    parameter int N_IRQ     = 4,
    parameter int ESTATUS_W = 4,
    parameter int EDGE_MODE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     ExtIRQ,
    input  logic [N_IRQ-1:0]     IrqEn,
    input  logic                 InvalidOp,
    input  logic                 ERet,
    input  logic                 ExcAck,
    output logic                 Exc,
    output logic [ESTATUS_W-1:0] EStatus,
    output logic [N_IRQ-1:0]     ExtIAck,
    output logic [N_IRQ-1:0]     IrqPending,
    output logic                 InHandler,
    output logic                 DoubleFault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_IRQ-1:0]       r_pend;
    logic [N_IRQ-1:0]       r_prev;
    logic [N_IRQ-1:0]       r_iack;
    logic [2:0]             r_sel;
    logic                   r_sel_irq;
    logic [ESTATUS_W-1:0]   r_estatus;
    logic                   r_exc;
    logic                   r_inh;
    logic                   r_dfault;

    logic [N_IRQ-1:0]       w_req;
    logic [N_IRQ-1:0]       w_sel_onehot;
    logic [N_IRQ-1:0]       w_clr;
    logic [N_IRQ-1:0]       w_pend_nxt;
    logic [N_IRQ-1:0]       w_iack_nxt;
    logic [2:0]             w_lowest;
    logic [2:0]             w_sel_nxt;
    logic                   w_sel_irq_nxt;
    logic [ESTATUS_W-1:0]   w_estatus_nxt;
    logic                   w_dfault_nxt;

    // Lowest set index wins; returns 0 for an empty vector (caller gates on |v).
    function automatic logic [2:0] f_lowest(input logic [N_IRQ-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = N_IRQ - 32'sd1; k >= 32'sd0; k--) begin
            if (v[k]) begin
                idx = 3'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign w_req        = r_pend & IrqEn;
    assign w_lowest     = f_lowest(w_req);
    assign w_sel_onehot = N_IRQ'(1'b1) << r_sel;

    // Next-state, cause selection, acknowledge and pending-vector update.
    always_comb begin
        w_state_nxt   = r_state;
        w_estatus_nxt = r_estatus;
        w_sel_nxt     = r_sel;
        w_sel_irq_nxt = r_sel_irq;
        w_iack_nxt    = '0;
        w_clr         = '0;
        w_dfault_nxt  = r_dfault;
        case (r_state)
            ST_IDLE: begin
                if (InvalidOp) begin
                    w_state_nxt   = ST_PEND;
                    w_estatus_nxt = ESTATUS_W'(4'd1);
                    w_sel_irq_nxt = 1'b0;
                end else if (|w_req) begin
                    w_state_nxt   = ST_PEND;
                    w_sel_nxt     = w_lowest;
                    w_sel_irq_nxt = 1'b1;
                    w_estatus_nxt = ESTATUS_W'(4'd8) + ESTATUS_W'(w_lowest);
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (ExcAck) begin
                    w_state_nxt = ST_SERV;
                    if (r_sel_irq) begin
                        w_iack_nxt = w_sel_onehot;
                        w_clr      = w_sel_onehot;
                    end else begin
                        w_iack_nxt = '0;
                    end
                end else begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_SERV: begin
                if (InvalidOp) begin
                    w_dfault_nxt = 1'b1;
                end else begin
                    w_dfault_nxt = r_dfault;
                end
                if (ERet) begin
                    w_state_nxt   = ST_IDLE;
                    w_estatus_nxt = '0;
                end else begin
                    w_state_nxt   = ST_SERV;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_estatus_nxt = '0;
            end
        endcase
        // A new edge on the line being acknowledged survives the clear.
        if (EDGE_MODE != 32'sd0) begin
            w_pend_nxt = (r_pend & ~w_clr) | (ExtIRQ & ~r_prev);
        end else begin
            w_pend_nxt = ExtIRQ;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; Exc/InHandler are registered decodes of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend    <= '0;
            r_prev    <= '0;
            r_iack    <= '0;
            r_sel     <= 3'd0;
            r_sel_irq <= 1'b0;
            r_estatus <= '0;
            r_exc     <= 1'b0;
            r_inh     <= 1'b0;
            r_dfault  <= 1'b0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_prev    <= ExtIRQ;
            r_iack    <= w_iack_nxt;
            r_sel     <= w_sel_nxt;
            r_sel_irq <= w_sel_irq_nxt;
            r_estatus <= w_estatus_nxt;
            r_exc     <= (w_state_nxt == ST_PEND);
            r_inh     <= (w_state_nxt == ST_SERV);
            r_dfault  <= w_dfault_nxt;
        end
    end

    assign Exc         = r_exc;
    assign EStatus     = r_estatus;
    assign ExtIAck     = r_iack;
    assign IrqPending  = r_pend;
    assign InHandler   = r_inh;
    assign DoubleFault = r_dfault;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Bench for exc_irq_ctrl: directed and random stimulus on an edge-mode instance
// against a behavioural model, plus directed checks on a level-mode instance.
module tb_exc_irq_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, inv, eret, ack;
    logic [N-1:0] irq, en;
    logic         exc, inh, df;
    logic [3:0]   est;
    logic [N-1:0] iack, pend;

    logic         l_reset, l_inv, l_eret, l_ack;
    logic [N-1:0] l_irq, l_en;
    logic         l_exc, l_inh, l_df;
    logic [3:0]   l_est;
    logic [N-1:0] l_iack, l_pend;

    int n_err = 0;
    int n_checks = 0;

    // Behavioural model of the edge-mode controller
    logic [N-1:0] m_pend, m_prev, m_ack;
    logic         m_exc, m_inh, m_df;
    int           m_cause;

    exc_irq_ctrl #(.N_IRQ(N), .ESTATUS_W(4), .EDGE_MODE(1)) u_dut (
        .clk(clk), .reset(reset), .ExtIRQ(irq), .IrqEn(en), .InvalidOp(inv),
        .ERet(eret), .ExcAck(ack), .Exc(exc), .EStatus(est), .ExtIAck(iack),
        .IrqPending(pend), .InHandler(inh), .DoubleFault(df)
    );

    exc_irq_ctrl #(.N_IRQ(N), .ESTATUS_W(4), .EDGE_MODE(0)) u_dut_lvl (
        .clk(clk), .reset(l_reset), .ExtIRQ(l_irq), .IrqEn(l_en), .InvalidOp(l_inv),
        .ERet(l_eret), .ExcAck(l_ack), .Exc(l_exc), .EStatus(l_est), .ExtIAck(l_iack),
        .IrqPending(l_pend), .InHandler(l_inh), .DoubleFault(l_df)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_ack = '0;
        m_exc = 1'b0; m_inh = 1'b0; m_df = 1'b0; m_cause = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] clr, req;
        bit took;
        clr = '0;
        if (m_exc) begin
            if (ack) begin
                m_exc = 1'b0;
                m_inh = 1'b1;
                if (m_cause >= 8) clr[m_cause-8] = 1'b1;
            end
        end else if (m_inh) begin
            if (inv) m_df = 1'b1;
            if (eret) begin
                m_inh = 1'b0;
                m_cause = 0;
            end
        end else if (inv) begin
            m_exc = 1'b1;
            m_cause = 1;
        end else begin
            req = m_pend & en;
            took = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (req[k] && !took) begin
                    took = 1'b1;
                    m_exc = 1'b1;
                    m_cause = 8 + k;
                end
            end
        end
        m_ack  = clr;
        m_pend = (m_pend & ~clr) | (irq & ~m_prev);
        m_prev = irq;
    endtask

    task automatic compare_all();
        check("exc",   32'(exc),  32'(m_exc));
        check("estat", 32'(est),  32'(m_cause));
        check("iack",  32'(iack), 32'(m_ack));
        check("pend",  32'(pend), 32'(m_pend));
        check("inh",   32'(inh),  32'(m_inh));
        check("dfault",32'(df),   32'(m_df));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic lstep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; l_reset = 1'b0;
        irq = '0; en = '0; inv = 1'b0; eret = 1'b0; ack = 1'b0;
        l_irq = '0; l_en = 4'hF; l_inv = 1'b0; l_eret = 1'b0; l_ack = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; l_reset = 1'b1;
        compare_all();
        check("rst_exc", 32'(exc), 32'd0);
        check("rst_est", 32'(est), 32'd0);

        // Single edge on line 2: 1 cycle to pending, 2 cycles to Exc
        en = 4'b1111;
        step();
        irq = 4'b0100; step();
        check("t1_pend", 32'(pend), 32'h4);
        check("t1_exc0", 32'(exc), 32'd0);
        step();
        check("t1_exc", 32'(exc), 32'd1);
        check("t1_est", 32'(est), 32'd10);
        ack = 1'b1; step();
        check("t1_iack", 32'(iack), 32'h4);
        check("t1_pclr", 32'(pend), 32'h0);
        check("t1_inh", 32'(inh), 32'd1);
        ack = 1'b0; step();
        check("t1_iack_off", 32'(iack), 32'h0);
        eret = 1'b1; step();
        check("t1_eret", 32'(est), 32'd0);
        eret = 1'b0; irq = '0; step();

        // Lines 1 and 2 together: 1 first, then 2 without a new edge
        irq = 4'b0110; step();
        step();
        check("t2_est1", 32'(est), 32'd9);
        ack = 1'b1; step();
        check("t2_iack1", 32'(iack), 32'h2);
        ack = 1'b0; irq = '0; eret = 1'b1; step();
        eret = 1'b0; step();
        check("t2_exc2", 32'(exc), 32'd1);
        check("t2_est2", 32'(est), 32'd10);
        ack = 1'b1; step();
        ack = 1'b0; eret = 1'b1; step();
        eret = 1'b0; step();

        // Disabled line stays pending until enabled
        en = 4'b0000; irq = 4'b1000; step();
        irq = '0; step(); step();
        check("t3_pend", 32'(pend), 32'h8);
        check("t3_noexc", 32'(exc), 32'd0);
        en = 4'b1000; step();
        check("t3_est", 32'(est), 32'd11);
        ack = 1'b1; step();
        ack = 1'b0; eret = 1'b1; step();
        eret = 1'b0; en = 4'b1111; step();

        // InvalidOp beats IRQ0; double fault in handler; IRQ0 after ERet
        inv = 1'b1; irq = 4'b0001; step();
        check("t4_est", 32'(est), 32'd1);
        check("t4_exc", 32'(exc), 32'd1);
        inv = 1'b0; irq = '0; ack = 1'b1; step();
        check("t4_noiack", 32'(iack), 32'h0);
        ack = 1'b0; inv = 1'b1; step();
        check("t4_df", 32'(df), 32'd1);
        check("t4_noexc", 32'(exc), 32'd0);
        inv = 1'b0; eret = 1'b1; step();
        eret = 1'b0; step();
        check("t4_irq0", 32'(est), 32'd8);
        ack = 1'b1; step();
        ack = 1'b0; eret = 1'b1; step();
        eret = 1'b0; step();

        // Async reset while a request is held
        irq = 4'b0100; step(); step();
        check("t5_inpend", 32'(exc), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("t5_exc", 32'(exc), 32'd0);
        check("t5_est", 32'(est), 32'd0);
        check("t5_pend", 32'(pend), 32'h0);
        check("t5_df", 32'(df), 32'd0);
        irq = '0;
        lstep();
        reset = 1'b1;
        step(); step(); step();
        check("t5_idle", 32'(exc), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) irq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) en = N'($urandom_range(0, 15));
            inv  = ($urandom_range(0, 15) == 0);
            ack  = ($urandom_range(0, 1) == 1);
            eret = ($urandom_range(0, 2) == 0);
            step();
        end
        irq = '0; inv = 1'b0; ack = 1'b0; eret = 1'b0;

        // Level mode: held line re-enters, dropped line returns to idle
        l_irq = 4'b0001; lstep();
        check("lv_pend", 32'(l_pend), 32'h1);
        lstep();
        check("lv_exc", 32'(l_exc), 32'd1);
        check("lv_est", 32'(l_est), 32'd8);
        l_ack = 1'b1; lstep();
        check("lv_iack", 32'(l_iack), 32'h1);
        check("lv_keep", 32'(l_pend), 32'h1);
        l_ack = 1'b0; l_eret = 1'b1; lstep();
        check("lv_idle", 32'(l_inh), 32'd0);
        l_eret = 1'b0; lstep();
        check("lv_reenter", 32'(l_exc), 32'd1);
        check("lv_reest", 32'(l_est), 32'd8);
        l_ack = 1'b1; lstep();
        l_ack = 1'b0; l_irq = '0; lstep();
        check("lv_drop", 32'(l_pend), 32'h0);
        l_eret = 1'b1; lstep();
        l_eret = 1'b0; lstep(); lstep();
        check("lv_rest", 32'(l_exc), 32'd0);
        check("lv_rest_est", 32'(l_est), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
